pipe_alu_regfile: RTL and testbench

- Parametrised, single-clock successor to the team's two-phase register-bank/ALU/memory pipeline.
- Four stages: operand read, execute, register writeback, memory write.
- Adds valid/ready handshakes, output backpressure, operand forwarding and a defined illegal-opcode response.
- Sits between the instruction sequencer and the scratch data memory.

---
 rtl/pipe_alu_regfile_pkg.sv | 47 ++++
 rtl/pipe_alu_exec.sv | 23 ++
 rtl/pipe_alu_regfile.sv | 164 ++++++++++++++++
 tb/tb_pipe_alu_regfile.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_regfile_pkg.sv
// Opcode encodings and the reference ALU function shared by pipe_alu_regfile.
// alu_op works at ALU_MAX_W bits; callers slice the low DATA_W bits (DATA_W <= ALU_MAX_W).
package pipe_alu_pkg;

    localparam int ALU_MAX_W = 32;

    localparam logic [3:0] FN_ADD   = 4'd0;
    localparam logic [3:0] FN_SUB   = 4'd1;
    localparam logic [3:0] FN_MUL   = 4'd2;
    localparam logic [3:0] FN_PASSA = 4'd3;
    localparam logic [3:0] FN_PASSB = 4'd4;
    localparam logic [3:0] FN_AND   = 4'd5;
    localparam logic [3:0] FN_OR    = 4'd6;
    localparam logic [3:0] FN_XOR   = 4'd7;
    localparam logic [3:0] FN_NEGA  = 4'd8;
    localparam logic [3:0] FN_NEGB  = 4'd9;
    localparam logic [3:0] FN_SHR   = 4'd10;
    localparam logic [3:0] FN_SHL   = 4'd11;
    localparam logic [3:0] FN_LAST  = 4'd11;

    // Returns {err, z}. Operands arrive zero-extended, so >>1 is a logical shift.
    function automatic logic [ALU_MAX_W:0] alu_op(input logic [ALU_MAX_W-1:0] a,
                                                  input logic [ALU_MAX_W-1:0] b,
                                                  input logic [3:0]           func);
        logic [ALU_MAX_W-1:0] z;
        logic                 err;
        z   = '0;
        err = 1'b0;
        case (func)
            FN_ADD:   z = a + b;
            FN_SUB:   z = a - b;
            FN_MUL:   z = a * b;
            FN_PASSA: z = a;
            FN_PASSB: z = b;
            FN_AND:   z = a & b;
            FN_OR:    z = a | b;
            FN_XOR:   z = a ^ b;
            FN_NEGA:  z = -a;
            FN_NEGB:  z = -b;
            FN_SHR:   z = a >> 1;
            FN_SHL:   z = a << 1;
            default:  err = 1'b1;
        endcase
        return {err, z};
    endfunction

endpackage

// File: rtl/pipe_alu_exec.sv
// Combinational execute stage: wraps alu_op and truncates the result to DATA_W.
module pipe_alu_exec
    import pipe_alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        func_i,
    output logic [DATA_W-1:0] z_o,
    output logic              err_o
);

    logic [ALU_MAX_W:0] res;
    logic               unused_hi;

    assign res       = alu_op(ALU_MAX_W'(a_i), ALU_MAX_W'(b_i), func_i);
    assign z_o       = res[DATA_W-1:0];
    assign err_o     = res[ALU_MAX_W];
    // Bits above DATA_W are the truncated overflow and are intentionally dropped.
    assign unused_hi = ^(res[ALU_MAX_W-1:0] >> DATA_W);

endmodule

// File: rtl/pipe_alu_regfile.sv
// Four-stage register-bank / ALU / scratch-memory pipeline with valid/ready flow control.
// Define PIPE_ALU_FWD_EN to enable operand forwarding from the S1 ALU output and S2 result.
//
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready; a result
// transfers where out_valid && out_ready. in_ready = !(out_valid && !out_ready), and while that
// stall holds every stage, the register bank and the memory keep their contents.
module pipe_alu_regfile
    import pipe_alu_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int REG_CNT   = 16,
    parameter  int MEM_DEPTH = 256,
    localparam int REG_AW    = $clog2(REG_CNT),
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        func,
    input  logic [ADDR_W-1:0] addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] zout,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_err,
    input  logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_rdata
);

    logic              stall;
    logic              accept;
    logic              rb_we;
    logic              mem_we;

    logic [DATA_W-1:0] regbank_q [REG_CNT];
    logic [DATA_W-1:0] mem_q     [MEM_DEPTH];

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_a_q;
    logic [DATA_W-1:0] s1_b_q;
    logic [REG_AW-1:0] s1_rd_q;
    logic [3:0]        s1_func_q;
    logic [ADDR_W-1:0] s1_addr_q;

    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_z_q;
    logic              s2_err_q;
    logic [REG_AW-1:0] s2_rd_q;
    logic [ADDR_W-1:0] s2_addr_q;

    logic              s3_valid_q;
    logic [DATA_W-1:0] s3_z_q;
    logic              s3_err_q;
    logic [REG_AW-1:0] s3_rd_q;
    logic [ADDR_W-1:0] s3_addr_q;

    logic [DATA_W-1:0] alu_z;
    logic              alu_err;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign stall    = s3_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign rb_we    = s2_valid_q && !stall;
    assign mem_we   = s3_valid_q && out_ready;

    assign out_valid = s3_valid_q;
    assign zout      = s3_z_q;
    assign out_rd    = s3_rd_q;
    assign out_err   = s3_err_q;
    assign mem_rdata = mem_q[mem_raddr];

    pipe_alu_exec #(
        .DATA_W (DATA_W)
    ) u_exec (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .func_i (s1_func_q),
        .z_o    (alu_z),
        .err_o  (alu_err)
    );

    // Later assignments win: the S1 ALU result is the youngest producer, then S2.
    // The S2 forward also covers the regbank write landing on the same edge.
    always_comb begin
        fwd_a = regbank_q[rs1];
        fwd_b = regbank_q[rs2];
`ifdef PIPE_ALU_FWD_EN
        if (s2_valid_q && s2_rd_q == rs1) fwd_a = s2_z_q;
        if (s2_valid_q && s2_rd_q == rs2) fwd_b = s2_z_q;
        if (s1_valid_q && s1_rd_q == rs1) fwd_a = alu_z;
        if (s1_valid_q && s1_rd_q == rs2) fwd_b = alu_z;
`endif
    end

    assign op_a = fwd_a;
    assign op_b = fwd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rd_q    <= '0;
            s1_func_q  <= '0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
            s2_err_q   <= 1'b0;
            s2_rd_q    <= '0;
            s2_addr_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_z_q     <= '0;
            s3_err_q   <= 1'b0;
            s3_rd_q    <= '0;
            s3_addr_q  <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q    <= op_a;
                s1_b_q    <= op_b;
                s1_rd_q   <= rd;
                s1_func_q <= func;
                s1_addr_q <= addr;
            end
            s2_valid_q <= s1_valid_q;
            s2_z_q     <= alu_z;
            s2_err_q   <= alu_err;
            s2_rd_q    <= s1_rd_q;
            s2_addr_q  <= s1_addr_q;
            s3_valid_q <= s2_valid_q;
            s3_z_q     <= s2_z_q;
            s3_err_q   <= s2_err_q;
            s3_rd_q    <= s2_rd_q;
            s3_addr_q  <= s2_addr_q;
        end
    end

    // Illegal opcodes still write their zero result back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regbank_q[i] <= '0;
            end
        end else if (rb_we) begin
            regbank_q[s2_rd_q] <= s2_z_q;
        end
    end

    // Scratch memory keeps its contents across reset; s3_valid_q is cleared so no write follows.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[s3_addr_q] <= s3_z_q;
        end
    end

endmodule

// File: tb/tb_pipe_alu_regfile.sv
// Directed bench for pipe_alu_regfile: a 16-bit and an 8-bit instance share the same stimulus.
module tb_pipe_alu_regfile;
    import pipe_alu_pkg::*;

    localparam int W = 32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic [7:0]  mem_raddr;

    logic        in_ready, out_valid, out_err;
    logic [3:0]  out_rd;
    logic [15:0] zout, mem_rdata;

    logic        in_ready8, out_valid8, out_err8;
    logic [3:0]  out_rd8;
    logic [7:0]  zout8, mem_rdata8;

    logic [15:0] force_v16;
    logic [7:0]  force_v8;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp8_q[$];
    logic [15:0]  mem_exp16 [int];
    logic [7:0]   mem_exp8 [int];

    int n_checks;
    int n_errors;

`ifdef PIPE_ALU_FWD_EN
    localparam logic [15:0] E_R11_16 = 16'd16;
    localparam logic [7:0]  E_R11_8  = 8'h22;
    localparam logic [15:0] E_R12_16 = 16'd13;
    localparam logic [7:0]  E_R12_8  = 8'hA1;
`else
    localparam logic [15:0] E_R11_16 = 16'd0;
    localparam logic [7:0]  E_R11_8  = 8'h00;
    localparam logic [15:0] E_R12_16 = 16'd5;
    localparam logic [7:0]  E_R12_8  = 8'h10;
`endif

    pipe_alu_regfile u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zout      (zout),
        .out_rd    (out_rd),
        .out_err   (out_err),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    pipe_alu_regfile #(.DATA_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .zout      (zout8),
        .out_rd    (out_rd8),
        .out_err   (out_err8),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata8)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic [3:0] f, input logic [7:0] ad);
        int   guard;
        logic acc;
        rs1 = a; rs2 = b; rd = d; func = f; addr = ad;
        in_valid = 1'b1;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("send_timeout", W'(acc), W'(1));
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [3:0] d, input logic [7:0] ad, input logic err,
                              input logic [15:0] z16, input logic [7:0] z8);
        exp_q.push_back(W'({err, d, z16}));
        exp8_q.push_back(W'({err, d, 8'h00, z8}));
        mem_exp16[int'(ad)] = z16;
        mem_exp8[int'(ad)]  = z8;
    endtask

    // Register loads: the operand path is overridden so PASSA writes a chosen value.
    task automatic load(input logic [3:0] d, input logic [15:0] v16, input logic [7:0] v8,
                        input logic [7:0] ad);
        force_v16 = v16;
        force_v8  = v8;
        force u_dut.op_a = force_v16;
        force u_dut8.op_a = force_v8;
        send(4'd0, 4'd0, d, FN_PASSA, ad);
        release u_dut.op_a;
        release u_dut8.op_a;
        expect_res(d, ad, 1'b0, v16, v8);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", W'(exp_q.size() + exp8_q.size()), W'(0));
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("res16_extra", W'({out_err, out_rd, zout}), '1);
            else check("res16", W'({out_err, out_rd, zout}), exp_q.pop_front());
        end
        if (out_valid8 && out_ready) begin
            if (exp8_q.size() == 0) check("res8_extra", W'({out_err8, out_rd8, 8'h00, zout8}), '1);
            else check("res8", W'({out_err8, out_rd8, 8'h00, zout8}), exp8_q.pop_front());
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
        mem_raddr = '0;
        force_v16 = '0;
        force_v8 = '0;
        idle(3);
        rst_n = 1'b1;

        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_zout", W'(zout), W'(0));
        check("rst_out_rd", W'(out_rd), W'(0));
        check("rst_out_err", W'(out_err), W'(0));
        check("rst_out_valid8", W'(out_valid8), W'(0));
        check("rst_in_ready8", W'(in_ready8), W'(1));

        // R1, R2 and memory words 40..42 preset
        load(4'd1, 16'd5, 8'h10, 8'd1);
        load(4'd2, 16'd3, 8'h81, 8'd2);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            send(4'd1, 4'd0, 4'd0, FN_PASSA, 8'(40 + i));
            expect_res(4'd0, 8'(40 + i), 1'b0, 16'd5, 8'h10);
        end
        idle(3);

        // independent back-to-back ops
        send(4'd1, 4'd2, 4'd4, FN_ADD, 8'd20);  expect_res(4'd4, 8'd20, 1'b0, 16'd8, 8'h91);
        send(4'd1, 4'd2, 4'd5, FN_MUL, 8'd21);  expect_res(4'd5, 8'd21, 1'b0, 16'd15, 8'h10);
        send(4'd1, 4'd1, 4'd6, FN_MUL, 8'd22);  expect_res(4'd6, 8'd22, 1'b0, 16'd25, 8'h00);
        send(4'd2, 4'd1, 4'd7, FN_SUB, 8'd23);  expect_res(4'd7, 8'd23, 1'b0, 16'hFFFE, 8'h71);
        send(4'd2, 4'd0, 4'd8, FN_SHL, 8'd24);  expect_res(4'd8, 8'd24, 1'b0, 16'd6, 8'h02);
        send(4'd2, 4'd0, 4'd9, FN_SHR, 8'd25);  expect_res(4'd9, 8'd25, 1'b0, 16'd1, 8'h40);
        send(4'd1, 4'd0, 4'd10, FN_NEGA, 8'd26); expect_res(4'd10, 8'd26, 1'b0, 16'hFFFB, 8'hF0);
        send(4'd0, 4'd2, 4'd11, FN_NEGB, 8'd27); expect_res(4'd11, 8'd27, 1'b0, 16'hFFFD, 8'h7F);
        idle(3);

        // dependency chain: S1 forward, then S2 forward on the regbank write edge
        send(4'd1, 4'd2, 4'd3, FN_ADD, 8'd28);  expect_res(4'd3, 8'd28, 1'b0, 16'd8, 8'h91);
        send(4'd3, 4'd3, 4'd11, FN_ADD, 8'd29); expect_res(4'd11, 8'd29, 1'b0, E_R11_16, E_R11_8);
        send(4'd3, 4'd1, 4'd12, FN_ADD, 8'd30); expect_res(4'd12, 8'd30, 1'b0, E_R12_16, E_R12_8);
        idle(3);
        send(4'd2, 4'd1, 4'd2, FN_ADD, 8'd31);  expect_res(4'd2, 8'd31, 1'b0, 16'd8, 8'h91);
        idle(3);

        // illegal opcode clears its destination
        load(4'd13, 16'd7, 8'h07, 8'd32);
        idle(3);
        send(4'd1, 4'd2, 4'd13, 4'd13, 8'd33);  expect_res(4'd13, 8'd33, 1'b1, 16'd0, 8'h00);
        idle(3);
        send(4'd13, 4'd0, 4'd14, FN_PASSA, 8'd34); expect_res(4'd14, 8'd34, 1'b0, 16'd0, 8'h00);
        idle(4);

        // backpressure: R1=5/0x10, R2=8/0x91
        out_ready = 1'b0;
        send(4'd1, 4'd2, 4'd15, FN_OR, 8'd40);  expect_res(4'd15, 8'd40, 1'b0, 16'd13, 8'h91);
        send(4'd1, 4'd2, 4'd14, FN_AND, 8'd41); expect_res(4'd14, 8'd41, 1'b0, 16'd0, 8'h10);
        send(4'd1, 4'd2, 4'd13, FN_XOR, 8'd42); expect_res(4'd13, 8'd42, 1'b0, 16'd13, 8'h81);
        rs1 = 4'd1; rs2 = 4'd2; rd = 4'd12; func = FN_ADD; addr = 8'd43;
        in_valid = 1'b1;
        mem_raddr = 8'd40;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", W'(in_ready), W'(0));
            check("bp_out_valid", W'(out_valid), W'(1));
            check("bp_zout", W'(zout), W'(16'd13));
            check("bp_zout8", W'(zout8), W'(8'h91));
            check("bp_mem", W'(mem_rdata), W'(16'd5));
            check("bp_mem8", W'(mem_rdata8), W'(8'h10));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(4'd1, 4'd2, 4'd12, FN_ADD, 8'd43); expect_res(4'd12, 8'd43, 1'b0, 16'd13, 8'hA1);
        drain();
        idle(2);

        // reset with three instructions in flight
        send(4'd1, 4'd0, 4'd4, FN_NEGA, 8'd1);
        send(4'd1, 4'd0, 4'd5, FN_NEGA, 8'd2);
        send(4'd1, 4'd2, 4'd6, FN_ADD, 8'd40);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_in_ready", W'(in_ready), W'(1));
        check("mid_rst_zout", W'(zout), W'(0));
        check("mid_rst_out_valid8", W'(out_valid8), W'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_out_valid", W'(out_valid), W'(0));
        for (int r = 0; r < 16; r++) begin
            send(4'(r), 4'd0, 4'(r), FN_PASSA, 8'(100 + r));
            expect_res(4'(r), 8'(100 + r), 1'b0, 16'd0, 8'h00);
        end
        drain();

        foreach (mem_exp16[a]) begin
            mem_raddr = 8'(a);
            #1;
            check($sformatf("mem16_%0d", a), W'(mem_rdata), W'(mem_exp16[a]));
            check($sformatf("mem8_%0d", a), W'(mem_rdata8), W'(mem_exp8[a]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
